// File: rtl/mode_controller.sv
// mode_controller: front end for the clock datapath.
//   Synchronises and debounces six push-buttons, turns accepted presses into one-mclk
//   pulses, runs the clk_mode / timer_mode state machines with their interlock, and
//   drops back to default mode after an inactivity timeout.
// Ports:
//   mclk        main clock
//   rst         asynchronous reset, active-low
//   pButton     raw buttons: [0] button1 [1] button2 [2] button3 [3] setampm [4] mode [5] timer
//   vButton     registered one-mclk pulses, same bit map (bits 2:0 gated by edit_active)
//   clk_mode    0 default, 1 set time, 2 set alarm, 3 set date
//   timer_mode  0 off, 1 set timer, 2 show/run timer
//   edit_active clk_mode != 0 or timer_mode == 1
module mode_controller #(
  parameter int unsigned M_FREQ     = 10,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT_S  = 3
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [5:0] pButton,
  output logic [5:0] vButton,
  output logic [1:0] clk_mode,
  output logic [1:0] timer_mode,
  output logic       edit_active
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned PreW  = $clog2(M_FREQ) + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_S) + 1;

  localparam logic [1:0] ClkDefault = 2'd0;
  localparam logic [1:0] TmrOff     = 2'd0;
  localparam logic [1:0] TmrSet     = 2'd1;
  localparam logic [1:0] TmrRun     = 2'd2;

  logic [5:0]      sync1_q, sync_q;
  logic [5:0]      stable_q, stable_d;
  logic [5:0]      prev_q;
  logic [5:0]      armed_q, armed_d;
  logic [1:0]      fill_q, fill_d;
  logic            sync_valid;
  logic [DebW-1:0] deb_cnt_q [6];
  logic [DebW-1:0] deb_cnt_d [6];
  logic [5:0]      raw;
  logic [5:0]      vbutton_d;
  logic [1:0]      clk_mode_q, clk_mode_d;
  logic [1:0]      timer_mode_q, timer_mode_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic            timeout;

  // The sync chain holds reset zeros for two edges; those must not count as a
  // genuine released sample, otherwise a button held through reset would pulse.
  assign sync_valid = (fill_q == 2'd2);
  assign fill_d     = sync_valid ? fill_q : fill_q + 2'd1;

  // A bit may only pulse once a real released sample has been seen after reset.
  assign armed_d = armed_q | ({6{sync_valid}} & ~sync_q);

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 6; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          stable_d[i] = sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  assign raw         = stable_q & ~prev_q & armed_q;
  assign edit_active = (clk_mode_q != ClkDefault) || (timer_mode_q == TmrSet);
  assign timeout     = (idle_q == IdleW'(TIMEOUT_S));
  assign vbutton_d   = {raw[5:3], raw[2:0] & {3{edit_active}}};

  always_comb begin
    clk_mode_d   = clk_mode_q;
    timer_mode_d = timer_mode_q;
    pre_d        = pre_q;
    idle_d       = idle_q;
    if (|raw) begin
      // Any press restarts the idle timer and beats a coincident timeout.
      pre_d  = '0;
      idle_d = '0;
      if (raw[4] && (timer_mode_q == TmrOff)) begin
        clk_mode_d = clk_mode_q + 2'd1;  // 3 wraps to 0
      end else if (raw[5] && (clk_mode_q == ClkDefault)) begin
        case (timer_mode_q)
          TmrOff:  timer_mode_d = TmrSet;
          TmrSet:  timer_mode_d = TmrRun;
          default: timer_mode_d = TmrOff;
        endcase
      end
    end else if (timeout) begin
      clk_mode_d = ClkDefault;
      if (timer_mode_q == TmrSet) begin
        timer_mode_d = TmrOff;
      end
      pre_d  = '0;
      idle_d = '0;
    end else if (!edit_active) begin
      pre_d  = '0;
      idle_d = '0;
    end else if (pre_q == PreW'(M_FREQ - 1)) begin
      pre_d  = '0;
      idle_d = idle_q + IdleW'(1);
    end else begin
      pre_d = pre_q + PreW'(1);
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      stable_q     <= '0;
      prev_q       <= '0;
      armed_q      <= '0;
      fill_q       <= '0;
      vButton      <= '0;
      clk_mode_q   <= ClkDefault;
      timer_mode_q <= TmrOff;
      pre_q        <= '0;
      idle_q       <= '0;
      for (int i = 0; i < 6; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= pButton;
      sync_q       <= sync1_q;
      stable_q     <= stable_d;
      prev_q       <= stable_q;
      armed_q      <= armed_d;
      fill_q       <= fill_d;
      vButton      <= vbutton_d;
      clk_mode_q   <= clk_mode_d;
      timer_mode_q <= timer_mode_d;
      pre_q        <= pre_d;
      idle_q       <= idle_d;
      for (int i = 0; i < 6; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign clk_mode   = clk_mode_q;
  assign timer_mode = timer_mode_q;

endmodule

// File: tb/tb_mode_controller.sv
module tb_mode_controller;

  logic       mclk = 1'b0;
  logic       rst;
  logic [5:0] pButton;
  logic [5:0] vButton;
  logic [1:0] clk_mode;
  logic [1:0] timer_mode;
  logic       edit_active;

  int checks = 0;
  int errors = 0;

  mode_controller #(
    .M_FREQ    (10),
    .DEB_CYCLES(4),
    .TIMEOUT_S (3)
  ) dut (
    .mclk       (mclk),
    .rst        (rst),
    .pButton    (pButton),
    .vButton    (vButton),
    .clk_mode   (clk_mode),
    .timer_mode (timer_mode),
    .edit_active(edit_active)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Holds button b for `hold` cycles then releases for 8; counts vButton[b] pulses.
  task automatic press(input int b, input int hold, output int npulse, output int first);
    npulse = 0;
    first  = -1;
    pButton[b] = 1'b1;
    for (int k = 1; k <= hold + 8; k++) begin
      if (k == hold + 1) pButton[b] = 1'b0;
      tick();
      if (vButton[b]) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pButton = '0;
    repeat (3) tick();
    checks++; if (vButton !== 6'd0) begin errors++;
      $display("FAIL reset_vbutton: got %b want 000000", vButton); end
    checks++; if (clk_mode !== 2'd0) begin errors++;
      $display("FAIL reset_clk_mode: got %0d want 0", clk_mode); end
    checks++; if (timer_mode !== 2'd0) begin errors++;
      $display("FAIL reset_timer_mode: got %0d want 0", timer_mode); end
    checks++; if (edit_active !== 1'b0) begin errors++;
      $display("FAIL reset_edit_active: got %b want 0", edit_active); end
    rst = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_mode_press();
    int n, f;
    press(4, 10, n, f);
    checks++; if (n != 1) begin errors++;
      $display("FAIL mode_pulse_count: got %0d want 1", n); end
    checks++; if (f != 7) begin errors++;
      $display("FAIL mode_pulse_latency: got %0d want 7", f); end
    checks++; if (clk_mode !== 2'd1) begin errors++;
      $display("FAIL mode_first_press: got %0d want 1", clk_mode); end
    checks++; if (edit_active !== 1'b1) begin errors++;
      $display("FAIL mode_edit_active: got %b want 1", edit_active); end
  endtask

  task automatic test_glitch_and_gate();
    int n, f, g;
    g = 0;
    pButton[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) pButton[0] = 1'b0;
      tick();
      if (vButton[0]) g++;
    end
    checks++; if (g != 0) begin errors++;
      $display("FAIL glitch_b0: got %0d pulses want 0", g); end
    press(0, 10, n, f);
    checks++; if (n != 1 || f != 7) begin errors++;
      $display("FAIL b0_edit_press: got %0d pulses at %0d want 1 at 7", n, f); end
    checks++; if (clk_mode !== 2'd1) begin errors++;
      $display("FAIL b0_keeps_mode: got %0d want 1", clk_mode); end
  endtask

  task automatic test_mode_cycle();
    int n, f;
    press(4, 10, n, f);
    checks++; if (clk_mode !== 2'd2) begin errors++;
      $display("FAIL cycle_to_2: got %0d want 2", clk_mode); end
    press(5, 10, n, f);
    checks++; if (n != 1) begin errors++;
      $display("FAIL timer_mirror: got %0d pulses want 1", n); end
    checks++; if (timer_mode !== 2'd0) begin errors++;
      $display("FAIL timer_interlock: got %0d want 0", timer_mode); end
    press(4, 10, n, f);
    checks++; if (clk_mode !== 2'd3) begin errors++;
      $display("FAIL cycle_to_3: got %0d want 3", clk_mode); end
    press(4, 10, n, f);
    checks++; if (clk_mode !== 2'd0) begin errors++;
      $display("FAIL cycle_to_0: got %0d want 0", clk_mode); end
    checks++; if (edit_active !== 1'b0) begin errors++;
      $display("FAIL cycle_edit_off: got %b want 0", edit_active); end
    press(0, 10, n, f);
    checks++; if (n != 0) begin errors++;
      $display("FAIL b0_gated: got %0d pulses want 0", n); end
  endtask

  task automatic test_timer();
    int n, f;
    press(5, 10, n, f);
    checks++; if (timer_mode !== 2'd1 || edit_active !== 1'b1) begin errors++;
      $display("FAIL timer_to_1: got mode %0d edit %b want 1 1", timer_mode, edit_active); end
    press(5, 10, n, f);
    checks++; if (timer_mode !== 2'd2 || edit_active !== 1'b0) begin errors++;
      $display("FAIL timer_to_2: got mode %0d edit %b want 2 0", timer_mode, edit_active); end
    press(4, 10, n, f);
    checks++; if (n != 1 || clk_mode !== 2'd0) begin errors++;
      $display("FAIL mode_in_timer: got %0d pulses clk_mode %0d want 1 0", n, clk_mode); end
    repeat (100) tick();
    checks++; if (timer_mode !== 2'd2) begin errors++;
      $display("FAIL timer_run_no_timeout: got %0d want 2", timer_mode); end
    press(5, 10, n, f);
    checks++; if (timer_mode !== 2'd0) begin errors++;
      $display("FAIL timer_to_0: got %0d want 0", timer_mode); end
  endtask

  // Raises mode and waits (bounded) for its pulse; returns 1 when seen.
  task automatic start_mode_press(output bit seen);
    seen = 1'b0;
    pButton[4] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (vButton[4]) seen = 1'b1;
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int z, p;
    start_mode_press(seen);
    checks++; if (!seen) begin errors++;
      $display("FAIL timeout_start: got no pulse want pulse"); end
    z = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 30) begin
        checks++; if (clk_mode !== 2'd1) begin errors++;
          $display("FAIL timeout_early: got %0d want 1 at cycle 30", clk_mode); end
      end
      if (clk_mode == 2'd0 && z < 0) z = n;
      if (n == 3) pButton[4] = 1'b0;
    end
    checks++; if (z != 31) begin errors++;
      $display("FAIL timeout_cycle: got %0d want 31", z); end
    start_mode_press(seen);
    z = -1;
    p = -1;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (vButton[0] && p < 0) p = n;
      if (clk_mode == 2'd0 && z < 0) z = n;
      if (n == 3) pButton[4] = 1'b0;
      if (n == 18) pButton[0] = 1'b1;
      if (n == 28) pButton[0] = 1'b0;
    end
    checks++; if (p != 25) begin errors++;
      $display("FAIL restart_pulse: got %0d want 25", p); end
    checks++; if (z != 56) begin errors++;
      $display("FAIL restart_timeout: got %0d want 56", z); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    seen = 1'b0;
    pButton[5:4] = 2'b11;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (vButton[4]) seen = 1'b1;
    end
    checks++; if (!seen || vButton[5] !== 1'b1) begin errors++;
      $display("FAIL simul_pulses: got seen %b v5 %b want 1 1", seen, vButton[5]); end
    checks++; if (clk_mode !== 2'd1 || timer_mode !== 2'd0) begin errors++;
      $display("FAIL simul_priority: got clk %0d tmr %0d want 1 0", clk_mode, timer_mode); end
    repeat (3) tick();
    pButton[5:4] = 2'b00;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_hold();
    int n, f, g;
    pButton[4] = 1'b1;
    repeat (10) tick();
    checks++; if (clk_mode !== 2'd2) begin errors++;
      $display("FAIL pre_reset_mode: got %0d want 2", clk_mode); end
    rst = 1'b0;
    #1;
    checks++; if (clk_mode !== 2'd0 || timer_mode !== 2'd0 || edit_active !== 1'b0
                  || vButton !== 6'd0) begin errors++;
      $display("FAIL async_reset: got clk %0d tmr %0d edit %b v %b want 0 0 0 0",
               clk_mode, timer_mode, edit_active, vButton); end
    repeat (3) tick();
    rst = 1'b1;
    g = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (vButton != 6'd0) g++;
    end
    checks++; if (g != 0 || clk_mode !== 2'd0) begin errors++;
      $display("FAIL held_after_reset: got %0d pulses clk %0d want 0 0", g, clk_mode); end
    pButton[4] = 1'b0;
    repeat (10) tick();
    press(4, 10, n, f);
    checks++; if (n != 1 || clk_mode !== 2'd1) begin errors++;
      $display("FAIL repress_after_reset: got %0d pulses clk %0d want 1 1", n, clk_mode); end
  endtask

  initial begin
    test_reset();
    test_mode_press();
    test_glitch_and_gate();
    test_mode_cycle();
    test_timer();
    test_timeout();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
